// File: rtl/asp_reliable_link_if.sv
// Host/network signal bundle for asp_reliable_link; slave is the link, master is its environment.
interface asp_reliable_link_if #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned TAG_SIZE  = 8,
    parameter int unsigned DEPTH     = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [TAG_SIZE-1:0]           secret_key;
    logic                          data_parity_ready_in;
    logic [DATA_SIZE:0]            data_parity_in;
    logic                          network_data_ready_in;
    logic                          network_ACK_in;
    logic [DATA_SIZE+TAG_SIZE-1:0] network_data_tag_in;
    logic                          parity_error_out;
    logic                          host_data_ready_out;
    logic [DATA_SIZE-1:0]          host_data_out;
    logic                          network_data_ready_out;
    logic                          network_ACK_out;
    logic [DATA_SIZE+TAG_SIZE-1:0] network_data_tag_out;
    logic                          auth_error_out;
    logic                          tx_fail_out;
    logic                          tx_full_out;
    logic [CNT_W-1:0]              outstanding_count_out;

    modport slave (
        input  secret_key, data_parity_ready_in, data_parity_in,
               network_data_ready_in, network_ACK_in, network_data_tag_in,
        output parity_error_out, host_data_ready_out, host_data_out,
               network_data_ready_out, network_ACK_out, network_data_tag_out,
               auth_error_out, tx_fail_out, tx_full_out, outstanding_count_out
    );

    modport master (
        output secret_key, data_parity_ready_in, data_parity_in,
               network_data_ready_in, network_ACK_in, network_data_tag_in,
        input  parity_error_out, host_data_ready_out, host_data_out,
               network_data_ready_out, network_ACK_out, network_data_tag_out,
               auth_error_out, tx_fail_out, tx_full_out, outstanding_count_out
    );
endinterface

// File: rtl/asp_reliable_link.sv
// Keyed-tag link: parity-checked TX with outstanding buffer, timeout retransmit and retry limit;
// tag-authenticated RX with ACK back to the network.
module asp_reliable_link #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned TAG_SIZE  = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              reset,
    asp_reliable_link_if.slave link
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned TMR_W  = $clog2(TIMEOUT);
    localparam int unsigned RTY_W  = $clog2(MAX_RETRY + 2);
    localparam int unsigned NSLICE = DATA_SIZE / TAG_SIZE;
    localparam int unsigned WORD_W = DATA_SIZE + TAG_SIZE;

    function automatic logic [TAG_SIZE-1:0] tag_of(input logic [DATA_SIZE-1:0] d,
                                                   input logic [TAG_SIZE-1:0]  k);
        logic [TAG_SIZE-1:0] t;
        t = k;
        for (int unsigned i = 0; i < NSLICE; i++) t = t ^ d[i*TAG_SIZE +: TAG_SIZE];
        return t;
    endfunction

    logic [WORD_W-1:0]  mem [DEPTH];
    logic               chk_valid;
    logic [DATA_SIZE:0] chk_word;
    logic [PTR_W-1:0]   head, tail;
    logic [CNT_W-1:0]   count, sent_cnt;
    logic [TMR_W-1:0]   timer;
    logic [RTY_W-1:0]   retry;
    logic               rx_valid;
    logic [WORD_W-1:0]  rx_word;

    logic               accept_c, parity_ok_c, write_c, head_sent_c, ack_c, timeout_c;
    logic               retx_c, drop_c, pop_c, send_new_c, rx_match_c;
    logic [PTR_W-1:0]   send_idx_c;
    logic [CNT_W-1:0]   count_n, sent_n;
    logic [TMR_W-1:0]   timer_n;
    logic [RTY_W-1:0]   retry_n;

    // Buffer occupancy plus an in-flight check-stage word decides back-pressure.
    assign link.tx_full_out = ({1'b0, count} + (CNT_W+1)'(chk_valid)) >= (CNT_W+1)'(DEPTH);
    assign link.outstanding_count_out = count;

    // TX control: acceptance, ACK/timeout arbitration, sender selection and next counters.
    always_comb begin
        accept_c    = link.data_parity_ready_in && !link.tx_full_out;
        parity_ok_c = ~^chk_word;
        write_c     = chk_valid && parity_ok_c;
        head_sent_c = sent_cnt != '0;
        ack_c       = link.network_ACK_in && head_sent_c;
        timeout_c   = head_sent_c && (timer == TMR_W'(TIMEOUT - 1)) && !ack_c;
        retx_c      = timeout_c && (retry < RTY_W'(MAX_RETRY));
        drop_c      = timeout_c && !retx_c;
        pop_c       = ack_c || drop_c;
        send_new_c  = !retx_c && (sent_cnt < count);
        send_idx_c  = head + PTR_W'(sent_cnt);
        count_n     = count + CNT_W'(write_c) - CNT_W'(pop_c);
        sent_n      = sent_cnt - CNT_W'(pop_c) + CNT_W'(send_new_c);
        retry_n     = retry;
        timer_n     = '0;
        if (pop_c)       retry_n = '0;
        else if (retx_c) retry_n = retry + RTY_W'(1);
        // Timer runs only while an already-sent head waits; any head change or head send restarts it.
        if (!pop_c && !retx_c && head_sent_c) timer_n = timer + TMR_W'(1);
        rx_match_c  = tag_of(rx_word[WORD_W-1:TAG_SIZE], link.secret_key) == rx_word[TAG_SIZE-1:0];
    end

    // Buffer storage; contents are meaningless outside [head, head+count) so no reset needed.
    always_ff @(posedge clk) begin
        if (write_c)
            mem[tail] <= {chk_word[DATA_SIZE:1], tag_of(chk_word[DATA_SIZE:1], link.secret_key)};
    end

    // TX state and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            chk_valid                   <= 1'b0;
            chk_word                    <= '0;
            head                        <= '0;
            tail                        <= '0;
            count                       <= '0;
            sent_cnt                    <= '0;
            timer                       <= '0;
            retry                       <= '0;
            link.parity_error_out       <= 1'b0;
            link.tx_fail_out            <= 1'b0;
            link.network_data_ready_out <= 1'b0;
            link.network_data_tag_out   <= '0;
        end else begin
            chk_valid <= accept_c;
            if (accept_c) chk_word <= link.data_parity_in;
            if (write_c)  tail <= tail + PTR_W'(1);
            if (pop_c)    head <= head + PTR_W'(1);
            count                       <= count_n;
            sent_cnt                    <= sent_n;
            timer                       <= timer_n;
            retry                       <= retry_n;
            link.parity_error_out       <= chk_valid && !parity_ok_c;
            link.tx_fail_out            <= drop_c;
            link.network_data_ready_out <= retx_c || send_new_c;
            if (retx_c)          link.network_data_tag_out <= mem[head];
            else if (send_new_c) link.network_data_tag_out <= mem[send_idx_c];
        end
    end

    // RX: sample the network word, then authenticate and report one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid                 <= 1'b0;
            rx_word                  <= '0;
            link.host_data_ready_out <= 1'b0;
            link.network_ACK_out     <= 1'b0;
            link.auth_error_out      <= 1'b0;
            link.host_data_out       <= '0;
        end else begin
            rx_valid                 <= link.network_data_ready_in;
            if (link.network_data_ready_in) rx_word <= link.network_data_tag_in;
            link.host_data_ready_out <= rx_valid && rx_match_c;
            link.network_ACK_out     <= rx_valid && rx_match_c;
            link.auth_error_out      <= rx_valid && !rx_match_c;
            if (rx_valid && rx_match_c) link.host_data_out <= rx_word[WORD_W-1:TAG_SIZE];
        end
    end
endmodule

// File: tb/tb_asp_reliable_link.sv
// Directed scoreboard bench for asp_reliable_link.
`timescale 1ns/1ps
module tb_asp_reliable_link;
    localparam int unsigned DATA_SIZE = 32;
    localparam int unsigned TAG_SIZE  = 8;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned TIMEOUT   = 16;
    localparam int unsigned MAX_RETRY = 3;
    localparam int unsigned WORD_W    = DATA_SIZE + TAG_SIZE;
    localparam logic [TAG_SIZE-1:0] KEY = 8'hA5;

    typedef struct {
        logic                 good;
        logic [DATA_SIZE-1:0] data;
    } rx_exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    asp_reliable_link_if #(.DATA_SIZE(DATA_SIZE), .TAG_SIZE(TAG_SIZE), .DEPTH(DEPTH)) link ();

    asp_reliable_link #(
        .DATA_SIZE(DATA_SIZE), .TAG_SIZE(TAG_SIZE), .DEPTH(DEPTH),
        .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .link (link)
    );

    logic [WORD_W-1:0] tx_q[$];
    rx_exp_t           rx_q[$];
    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int send_cnt = 0;
    int perr_cnt = 0;
    int fail_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TAG_SIZE-1:0] model_tag(input logic [DATA_SIZE-1:0] d);
        logic [DATA_SIZE-1:0] r;
        logic [TAG_SIZE-1:0]  t;
        r = d;
        t = KEY;
        repeat (DATA_SIZE / TAG_SIZE) begin
            t = t ^ r[TAG_SIZE-1:0];
            r = r >> TAG_SIZE;
        end
        return t;
    endfunction

    function automatic logic [DATA_SIZE:0] host_word(input logic [DATA_SIZE-1:0] d, input logic good);
        return {d, (^d) ^ ~good};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_host(input logic [DATA_SIZE:0] w);
        link.data_parity_ready_in = 1'b1;
        link.data_parity_in       = w;
        step(1);
        link.data_parity_ready_in = 1'b0;
    endtask

    // Scoreboard: every network send and every RX report is matched against queued expectations.
    always @(negedge clk) begin
        if (!reset) begin
            if (link.network_data_ready_out) begin
                send_cnt++;
                chk("tx_send_expected", 64'(tx_q.size() != 0), 64'd1);
                if (tx_q.size() != 0) chk("tx_word", 64'(link.network_data_tag_out), 64'(tx_q.pop_front()));
            end
            if (link.host_data_ready_out || link.auth_error_out) begin
                chk("rx_report_expected", 64'(rx_q.size() != 0), 64'd1);
                if (rx_q.size() != 0) begin
                    rx_exp_t e;
                    e = rx_q.pop_front();
                    chk("rx_ready", 64'(link.host_data_ready_out), 64'(e.good));
                    chk("rx_ack",   64'(link.network_ACK_out),     64'(e.good));
                    chk("rx_auth",  64'(link.auth_error_out),      64'(!e.good));
                    chk("rx_data",  64'(link.host_data_out),       64'(e.data));
                end
            end
            if (link.parity_error_out) perr_cnt++;
            if (link.tx_fail_out) fail_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, s, base_send, base_fail, ack_edge;
        logic [DATA_SIZE-1:0] w [5];
        w[0] = 32'h12345678; w[1] = 32'hDEADBEEF; w[2] = 32'h0BADF00D;
        w[3] = 32'hCAFEBABE; w[4] = 32'h55AA00FF;
        link.secret_key            = KEY;
        link.data_parity_ready_in  = 1'b0;
        link.data_parity_in        = '0;
        link.network_data_ready_in = 1'b0;
        link.network_ACK_in        = 1'b0;
        link.network_data_tag_in   = '0;

        // Reset state
        reset = 1'b1;
        step(3);
        chk("rst_count",   64'(link.outstanding_count_out), 64'd0);
        chk("rst_full",    64'(link.tx_full_out), 64'd0);
        chk("rst_nready",  64'(link.network_data_ready_out), 64'd0);
        chk("rst_hostdat", 64'(link.host_data_out), 64'd0);
        reset = 1'b0;
        step(1);

        // Good TX then ACK
        tx_q.push_back(40'h12345678AD);
        chk("model_tag_ref", 64'({w[0], model_tag(w[0])}), 64'h12345678AD);
        send_host({32'h12345678, 1'b1});
        t = cyc;
        step(1);
        chk("good_count", 64'(link.outstanding_count_out), 64'd1);
        chk("good_not_yet", 64'(link.network_data_ready_out), 64'd0);
        step(1);
        chk("good_ready", 64'(link.network_data_ready_out), 64'd1);
        chk("good_tag", 64'(link.network_data_tag_out), 64'h12345678AD);
        step(1);
        chk("good_pulse_end", 64'(link.network_data_ready_out), 64'd0);
        link.network_ACK_in = 1'b1;
        step(1);
        link.network_ACK_in = 1'b0;
        chk("good_acked_count", 64'(link.outstanding_count_out), 64'd0);

        // Parity error
        base_send = send_cnt;
        send_host({32'h12345678, 1'b0});
        step(1);
        chk("perr_pulse", 64'(link.parity_error_out), 64'd1);
        chk("perr_count", 64'(link.outstanding_count_out), 64'd0);
        step(1);
        chk("perr_pulse_end", 64'(link.parity_error_out), 64'd0);
        step(3);
        chk("perr_no_send", 64'(send_cnt - base_send), 64'd0);

        // Retry then drop
        base_send = send_cnt;
        base_fail = fail_cnt;
        repeat (MAX_RETRY + 1) tx_q.push_back({w[0], model_tag(w[0])});
        send_host(host_word(w[0], 1'b1));
        s = cyc + 2;
        goto(s);
        chk("retry_first_send", 64'(link.network_data_ready_out), 64'd1);
        for (int k = 1; k <= int'(MAX_RETRY); k++) begin
            goto(s + k * int'(TIMEOUT) - 1);
            chk("retry_not_early", 64'(link.network_data_ready_out), 64'd0);
            step(1);
            chk("retry_resend", 64'(link.network_data_ready_out), 64'd1);
        end
        goto(s + (int'(MAX_RETRY) + 1) * int'(TIMEOUT) - 1);
        chk("fail_not_early", 64'(link.tx_fail_out), 64'd0);
        step(1);
        chk("fail_pulse", 64'(link.tx_fail_out), 64'd1);
        chk("fail_no_resend", 64'(link.network_data_ready_out), 64'd0);
        chk("fail_count", 64'(link.outstanding_count_out), 64'd0);
        step(20);
        chk("fail_total_sends", 64'(send_cnt - base_send), 64'(MAX_RETRY + 1));
        chk("fail_total_pulses", 64'(fail_cnt - base_fail), 64'd1);

        // Full / back-pressure
        for (int i = 0; i < 4; i++) tx_q.push_back({w[i], model_tag(w[i])});
        for (int i = 0; i < 4; i++) send_host(host_word(w[i], 1'b1));
        chk("full_after_4th", 64'(link.tx_full_out), 64'd1);
        send_host(host_word(w[4], 1'b1));
        chk("full_count", 64'(link.outstanding_count_out), 64'd4);
        chk("full_held", 64'(link.tx_full_out), 64'd1);
        step(1);
        link.network_ACK_in = 1'b1;
        step(1);
        link.network_ACK_in = 1'b0;
        ack_edge = cyc;
        chk("full_released", 64'(link.tx_full_out), 64'd0);
        chk("full_count_after_ack", 64'(link.outstanding_count_out), 64'd3);
        tx_q.push_back({w[1], model_tag(w[1])});
        goto(ack_edge + int'(TIMEOUT));
        chk("full_head_is_2nd", 64'(link.network_data_tag_out), 64'({w[1], model_tag(w[1])}));
        chk("full_head_resend", 64'(link.network_data_ready_out), 64'd1);
        link.network_ACK_in = 1'b1;
        step(3);
        link.network_ACK_in = 1'b0;
        chk("full_drained", 64'(link.outstanding_count_out), 64'd0);

        // ACK lands exactly in the timeout cycle
        base_send = send_cnt;
        tx_q.push_back({w[2], model_tag(w[2])});
        send_host(host_word(w[2], 1'b1));
        s = cyc + 2;
        goto(s + int'(TIMEOUT) - 1);
        link.network_ACK_in = 1'b1;
        step(1);
        link.network_ACK_in = 1'b0;
        chk("ackto_no_resend", 64'(link.network_data_ready_out), 64'd0);
        chk("ackto_count", 64'(link.outstanding_count_out), 64'd0);
        step(20);
        chk("ackto_single_send", 64'(send_cnt - base_send), 64'd1);

        // RX good, bad tag, good with new data
        rx_q.push_back('{good: 1'b1, data: 32'h12345678});
        link.network_data_ready_in = 1'b1;
        link.network_data_tag_in   = 40'h12345678AD;
        step(1);
        link.network_data_ready_in = 1'b0;
        step(1);
        chk("rx_good_ready", 64'(link.host_data_ready_out), 64'd1);
        chk("rx_good_data", 64'(link.host_data_out), 64'h12345678);
        rx_q.push_back('{good: 1'b0, data: 32'h12345678});
        link.network_data_ready_in = 1'b1;
        link.network_data_tag_in   = 40'h12345678AC;
        step(1);
        link.network_data_ready_in = 1'b0;
        step(1);
        chk("rx_bad_auth", 64'(link.auth_error_out), 64'd1);
        chk("rx_bad_noack", 64'(link.network_ACK_out), 64'd0);
        rx_q.push_back('{good: 1'b1, data: w[3]});
        link.network_data_ready_in = 1'b1;
        link.network_data_tag_in   = {w[3], model_tag(w[3])};
        step(1);
        link.network_data_ready_in = 1'b0;
        step(1);
        chk("rx_good2_data", 64'(link.host_data_out), 64'(w[3]));

        // Reset with 3 outstanding
        for (int i = 0; i < 3; i++) tx_q.push_back({w[i], model_tag(w[i])});
        for (int i = 0; i < 3; i++) send_host(host_word(w[i], 1'b1));
        step(3);
        chk("rst3_count_before", 64'(link.outstanding_count_out), 64'd3);
        base_send = send_cnt;
        base_fail = fail_cnt;
        reset = 1'b1;
        step(1);
        chk("rst3_count", 64'(link.outstanding_count_out), 64'd0);
        chk("rst3_fail", 64'(link.tx_fail_out), 64'd0);
        chk("rst3_full", 64'(link.tx_full_out), 64'd0);
        chk("rst3_nready", 64'(link.network_data_ready_out), 64'd0);
        chk("rst3_tag", 64'(link.network_data_tag_out), 64'd0);
        chk("rst3_hostdat", 64'(link.host_data_out), 64'd0);
        reset = 1'b0;
        tx_q.delete();
        step(80);
        chk("rst3_no_sends", 64'(send_cnt - base_send), 64'd0);
        chk("rst3_no_fail", 64'(fail_cnt - base_fail), 64'd0);
        chk("perr_total", 64'(perr_cnt), 64'd1);
        chk("tx_q_empty", 64'(tx_q.size()), 64'd0);
        chk("rx_q_empty", 64'(rx_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
